// File: rtl/data_mem_pkg.sv
// Shared constants for the MEM-stage data memory controller:
// access sizes, FSM state encoding and wait-counter width.
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised byte storage with per-lane write enables.
// Lane 0 is the most significant byte (big-endian layout).
module data_mem_array #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned IW          = 6
) (
    input  logic          clk,
    input  logic [IW-1:0] index,
    input  logic [3:0]    be,
    input  logic [31:0]   wword,
    output logic [31:0]   rword
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
                mem[index][31-8*l -: 8] <= wword[31-8*l -: 8];
            end
        end
    end

    assign rword = mem[index];

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked big-endian data memory for the MEM stage with
// configurable base address, depth and wait states.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        resp_err
);

    localparam int unsigned IW =
        (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) - 2 : 1;
    localparam logic [31:0] DEPTH32 = 32'(DEPTH_BYTES);
    localparam logic NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             l_write;
    logic [1:0]       l_size;
    logic [31:0]      l_addr;
    logic [31:0]      l_wdata;

    logic             in_idle;
    logic             accept;
    logic             to_resp;
    logic             c_write;
    logic [1:0]       c_size;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [31:0]      offset;
    logic [1:0]       lane;
    logic             err;
    logic [3:0]       be;
    logic [3:0]       we;
    logic [31:0]      wword;
    logic [31:0]      rword;
    logic [31:0]      rsh;
    logic [31:0]      rsteer;
    logic [31:0]      rd_val;

    assign in_idle    = (state == ST_IDLE);
    assign req_ready  = in_idle;
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_valid && in_idle && rst;

    // With no wait states the commit edge is the acceptance edge,
    // so the live request is used instead of the latched copy.
    assign c_write = in_idle ? req_write : l_write;
    assign c_size  = in_idle ? req_size  : l_size;
    assign c_addr  = in_idle ? address   : l_addr;
    assign c_wdata = in_idle ? wdata     : l_wdata;

    assign to_resp = (accept && NO_WAIT)
                  || ((state == ST_WAIT) && (cnt == '0));

    assign offset = c_addr - BASE_ADDR;
    assign lane   = offset[1:0];

    assign err = (c_addr < BASE_ADDR)
              || (offset >= DEPTH32)
              || (c_size == SIZE_RSVD)
              || ((c_size == SIZE_HALF) && c_addr[0])
              || ((c_size == SIZE_WORD) && (c_addr[1:0] != 2'b00));

    always_comb begin
        be     = 4'b1111;
        wword  = c_wdata;
        rsh    = rword << {lane, 3'b000};
        rsteer = rword;
        unique case (c_size)
            SIZE_BYTE: begin
                be     = 4'b0001 << lane;
                wword  = {4{c_wdata[7:0]}};
                rsteer = {24'h0, rsh[31:24]};
            end
            SIZE_HALF: begin
                be     = 4'b0011 << lane;
                wword  = {2{c_wdata[15:0]}};
                rsteer = {16'h0, rsh[31:16]};
            end
            default: begin
                be     = 4'b1111;
                wword  = c_wdata;
                rsteer = rword;
            end
        endcase
    end

    assign we     = (to_resp && !err && c_write) ? be : 4'b0000;
    assign rd_val = (err || c_write) ? 32'h0 : rsteer;

    data_mem_array #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .IW         (IW)
    ) u_array (
        .clk  (clk),
        .index(offset[IW+1:2]),
        .be   (we),
        .wword(wword),
        .rword(rword)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            l_write  <= 1'b0;
            l_size   <= SIZE_BYTE;
            l_addr   <= '0;
            l_wdata  <= '0;
            rdata    <= '0;
            resp_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        l_write <= req_write;
                        l_size  <= req_size;
                        l_addr  <= address;
                        l_wdata <= wdata;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (to_resp) begin
                rdata    <= rd_val;
                resp_err <= err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with wait-state variants 1, 0 and 5.
// Slot 0 carries the functional traffic; slots 1 and 2 measure latency.
module tb_data_mem_ctrl;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid  = '0;
    logic [2:0]  resp_ready = '0;
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_err;
    logic        req_write = 1'b0;
    logic [1:0]  req_size  = '0;
    logic [31:0] address   = '0;
    logic [31:0] wdata     = '0;
    logic [31:0] rdata [3];

    always #5 clk = ~clk;

    data_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH),
                    .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_size(req_size),
        .address(address), .wdata(wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .rdata(rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH),
                    .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_size(req_size),
        .address(address), .wdata(wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .rdata(rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH),
                    .WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write), .req_size(req_size),
        .address(address), .wdata(wdata),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .rdata(rdata[2]), .resp_err(resp_err[2])
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  mm [DEPTH];
    logic [32:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-array reference model; returns {err, rdata}.
    task automatic model(input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [32:0] r);
        logic [31:0] o;
        bit bad;
        int i;
        o   = a - BASE;
        bad = (a < BASE) || (o >= 32'(DEPTH)) || (sz == 2'd3)
           || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        r   = '0;
        i   = int'(o);
        if (bad) begin
            r = {1'b1, 32'h0};
        end else if (wr) begin
            case (sz)
                2'd0: mm[i] = wd[7:0];
                2'd1: begin
                    mm[i]   = wd[15:8];
                    mm[i+1] = wd[7:0];
                end
                default: begin
                    mm[i]   = wd[31:24];
                    mm[i+1] = wd[23:16];
                    mm[i+2] = wd[15:8];
                    mm[i+3] = wd[7:0];
                end
            endcase
        end else begin
            case (sz)
                2'd0:    r = {1'b0, 24'h0, mm[i]};
                2'd1:    r = {1'b0, 16'h0, mm[i], mm[i+1]};
                default: r = {1'b0, mm[i], mm[i+1], mm[i+2], mm[i+3]};
            endcase
        end
    endtask

    task automatic txn(input int d, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold, input int exp_lat);
        int n;
        logic [32:0] e;
        @(negedge clk);
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            check("req_ready_timeout", 32'(req_ready[d]), 32'd1);
            return;
        end
        req_write    = wr;
        req_size     = sz;
        address      = a;
        wdata        = wd;
        req_valid[d] = 1'b1;
        model(wr, sz, a, wd, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        address      = $urandom;
        wdata        = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[d] && n < 64);
        check("resp_valid", 32'(resp_valid[d]), 32'd1);
        if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
        e = sb.pop_front();
        check("rdata", rdata[d], e[31:0]);
        check("resp_err", 32'(resp_err[d]), 32'(e[32]));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("bp_valid", 32'(resp_valid[d]), 32'd1);
            check("bp_rdata", rdata[d], e[31:0]);
            check("bp_err", 32'(resp_err[d]), 32'(e[32]));
            check("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        if (hold > 0) check("bp_release", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_resp_err", 32'(resp_err[0]), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < DEPTH / 4; i++)
            txn(0, 1'b1, 2'd2, BASE + 32'(4 * i), $urandom, 0, 2);

        txn(0, 1'b1, 2'd2, BASE, 32'hDEADBEEF, 0, 2);
        txn(0, 1'b0, 2'd2, BASE, 32'h0, 0, 2);
        txn(0, 1'b0, 2'd0, BASE + 3, 32'h0, 0, 2);
        txn(0, 1'b1, 2'd0, BASE + 1, 32'h00000011, 0, 2);
        txn(0, 1'b1, 2'd1, BASE + 2, 32'h0000A5A5, 0, 2);
        txn(0, 1'b0, 2'd2, BASE, 32'h0, 0, 2);
        txn(0, 1'b0, 2'd1, BASE + 2, 32'h0, 0, 2);

        txn(0, 1'b1, 2'd2, BASE + 2, 32'hFFFFFFFF, 0, 2);
        txn(0, 1'b1, 2'd1, BASE + 1, 32'hFFFFFFFF, 0, 2);
        txn(0, 1'b1, 2'd3, BASE, 32'hFFFFFFFF, 0, 2);
        txn(0, 1'b1, 2'd0, BASE - 1, 32'hFFFFFFFF, 0, 2);
        txn(0, 1'b1, 2'd2, BASE + DEPTH, 32'hFFFFFFFF, 0, 2);
        txn(0, 1'b0, 2'd3, BASE, 32'h0, 0, 2);
        txn(0, 1'b0, 2'd2, BASE + 2, 32'h0, 0, 2);
        txn(0, 1'b0, 2'd2, BASE, 32'h0, 0, 2);
        txn(0, 1'b0, 2'd2, BASE + DEPTH - 4, 32'h0, 0, 2);

        txn(0, 1'b0, 2'd2, BASE, 32'h0, 10, 2);

        txn(1, 1'b0, 2'd2, BASE - 1, 32'h0, 0, 1);
        txn(2, 1'b0, 2'd2, BASE - 1, 32'h0, 0, 6);
        txn(1, 1'b0, 2'd3, BASE, 32'h0, 0, 1);

        // Abort a write while it is still waiting.
        @(negedge clk);
        address      = BASE;
        wdata        = 32'h12345678;
        req_write    = 1'b1;
        req_size     = 2'd2;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("abort_in_wait", 32'({resp_valid[0], req_ready[0]}), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready[0]), 32'd1);
        check("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("abort_rdata", rdata[0], 32'd0);
        check("abort_resp_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 2'd2, BASE, 32'h0, 0, 2);

        for (int i = 0; i < 60; i++) begin
            txn(0, 1'($urandom), 2'($urandom),
                BASE - 4 + 32'($urandom_range(0, DEPTH + 7)),
                $urandom, 0, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the ARM datapath's MEM stage. It provides byte-addressed, big-endian storage at a configurable base address, with byte, halfword and word accesses and a programmable number of wait states. Misaligned, out-of-range and reserved-size accesses return an error response and leave memory unchanged. Requests and responses use valid/ready handshakes, so the pipeline can stall on memory latency.

## Interface
- BASE_ADDR, 1024: first byte address mapped to the array.
- DEPTH_BYTES, 256: array size in bytes; power of two, ≥ 4.
- WAIT_CYCLES, 1: extra cycles between acceptance and response, range 0..15.
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- req_valid  input  1: request present.
- req_ready  output  1: block can accept a request.
- req_write  input  1: 1 = write, 0 = read.
- req_size  input  2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- address  input  32: byte address.
- wdata  input  32: write data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1: response present.
- resp_ready  input  1: consumer accepts the response.
- rdata  output  32: read data, zero-extended and right-aligned; 0 for writes and errors.
- resp_err  output  1: access was rejected.

## Operation
- FSM states are IDLE, WAIT and RESP. req_ready = (state == IDLE), driven combinationally from state.
- Acceptance: req_valid && req_ready at a rising edge. On acceptance the block latches req_write, req_size, address and wdata.
- Next state after acceptance:
  - WAIT_CYCLES = 0: RESP.
  - Otherwise: WAIT, with wait counter loaded to WAIT_CYCLES-1. The counter decrements each cycle, and WAIT goes to RESP when it reaches 0.
- Offset: 32-bit offset = address - BASE_ADDR.
- Error when any of the following holds:
  - address < BASE_ADDR;
  - offset ≥ DEPTH_BYTES;
  - req_size == 3;
  - half access with address[0] = 1;
  - word access with address[1:0] ≠ 0.
- Commit edge: the edge entering RESP.
  - Legal write: updates only the addressed bytes.
  - Legal read: loads rdata.
  - Error: sets resp_err, loads rdata = 0, and performs no array write.
- Byte order is big-endian:
  - word: mem[o] holds bits [31:24] and mem[o+3] holds bits [7:0];
  - half: {mem[o], mem[o+1]} maps to [15:0].
- RESP: resp_valid = 1, and rdata and resp_err are held stable. On resp_ready the FSM returns to IDLE and resp_valid falls.
- No request is accepted outside IDLE. There is one outstanding transaction at most.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, rdata 0, resp_err 0, wait counter 0.
- Response latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- Minimum throughput: one transaction every WAIT_CYCLES+2 cycles when resp_ready is held high.
- A write becomes visible to a read accepted at or after its response.
- Reset asserted before the commit edge aborts the transaction with no array write. Reset asserted in RESP drops resp_valid immediately.
- req_valid while not ready: the request is ignored, and the requester must hold it.
- address, wdata, req_write and req_size may change freely after acceptance without affecting the transaction.

## Structure
- Package data_mem_pkg holds:
  - size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD and SIZE_RSVD;
  - the state encoding (IDLE, WAIT, RESP);
  - the wait-counter width (4).
- Sub-module data_mem_array holds:
  - DEPTH_BYTES × 8 storage;
  - one word-aligned index;
  - a 4-bit byte-write-enable (lane 0 = MSB byte);
  - a 32-bit write word and a combinational 32-bit read word.
- The top level contains the FSM, error check, lane steering and response registers.

## Test plan
- Word write then word read: write 0xDEADBEEF to 1024, then read 1024 -> rdata 0xDEADBEEF and resp_err 0. Then byte read at 1027 -> 0x000000EF.
- Byte and half writes:
  - Starting from the word above, write byte 0x11 to 1025 and half 0xA5A5 to 1026.
  - Word read at 1024 -> 0xDE11A5A5.
- Errors, each giving resp_err 1 and rdata 0 with memory unchanged:
  - word at 1026;
  - half at 1025;
  - size 3;
  - address 1023;
  - address 1024+DEPTH_BYTES.
- Latency with WAIT_CYCLES = 0, 1 and 5: resp_valid rises exactly 1, 2 and 6 cycles after acceptance.
- Backpressure: hold resp_ready low for 10 cycles -> resp_valid, rdata and resp_err stay stable and req_ready stays 0. Then release resp_ready -> req_ready returns 1 on the next cycle.
- Reset mid-transaction: assert rst in WAIT during a write of 0x12345678 -> outputs return to reset values, and a later read of that address shows the old contents.
